// File: rtl/fetch_sequencer.sv
// Multi-byte instruction fetch stage for the SAP-2 CPU: owns the PC, drives the memory bus,
// latches opcode/operands and hands off to execute. Optional macro: FETCH_LEN_TRAP_EN (length-0 trap).
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hF000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [1:0]            instr_len,
    input  logic                  exec_done,
    input  logic                  jump_load,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] opcode_out,
    output logic [DATA_WIDTH-1:0] operand_1,
    output logic [DATA_WIDTH-1:0] operand_2,
    output logic                  load_origin,
    output logic                  fetch_done,
    output logic                  halted,
    output logic                  fault
);

    typedef enum logic [2:0] {
        S_INIT,
        S_LATCH_ADDRESS,
        S_READ_BYTE,
        S_LATCH_BYTE,
        S_CHK_MORE_BYTES,
        S_EXEC_WAIT,
        S_HALTED
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] byte_idx;
    logic [1:0] len_eff;
    logic       more_bytes;
    logic       len_trap;

    // A decoded length of 0 is never a real instruction; without the trap it fetches as 1 byte.
    assign len_eff    = (instr_len == 2'd0) ? 2'd1 : instr_len;
    assign more_bytes = (byte_idx < len_eff);

`ifdef FETCH_LEN_TRAP_EN
    assign len_trap = (state == S_CHK_MORE_BYTES) && (instr_len == 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (len_trap) begin
            fault <= 1'b1;
        end
    end
`else
    assign len_trap = 1'b0;
    assign fault    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, otherwise partial paths infer latches.
    always_comb begin
        state_next  = state;
        load_origin = 1'b0;
        mem_read    = 1'b0;
        fetch_done  = 1'b0;
        case (state)
            S_INIT: begin
                load_origin = 1'b1;
                state_next  = S_LATCH_ADDRESS;
            end
            S_LATCH_ADDRESS: state_next = S_READ_BYTE;
            S_READ_BYTE: begin
                mem_read   = 1'b1;
                state_next = S_LATCH_BYTE;
            end
            S_LATCH_BYTE: state_next = S_CHK_MORE_BYTES;
            S_CHK_MORE_BYTES: begin
                if (len_trap) begin
                    state_next = S_HALTED;
                end else if (more_bytes) begin
                    state_next = S_LATCH_ADDRESS;
                end else begin
                    fetch_done = 1'b1;
                    state_next = S_EXEC_WAIT;
                end
            end
            S_EXEC_WAIT: begin
                if (exec_done) begin
                    state_next = halt ? S_HALTED : S_LATCH_ADDRESS;
                end
            end
            S_HALTED: state_next = S_HALTED;
            default:  state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out      <= '0;
            mem_address <= '0;
            opcode_out  <= '0;
            operand_1   <= '0;
            operand_2   <= '0;
            byte_idx    <= 2'd0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_INIT:          pc_out      <= RESET_VECTOR;
                S_LATCH_ADDRESS: mem_address <= pc_out;
                S_LATCH_BYTE: begin
                    case (byte_idx)
                        2'd0:    opcode_out <= mem_data_in;
                        2'd1:    operand_1  <= mem_data_in;
                        default: operand_2  <= mem_data_in;
                    endcase
                    pc_out   <= pc_out + 1'b1;
                    byte_idx <= byte_idx + 2'd1;
                end
                S_CHK_MORE_BYTES: begin
                    if (len_trap) begin
                        halted   <= 1'b1;
                        byte_idx <= 2'd0;
                    end else if (!more_bytes) begin
                        byte_idx <= 2'd0;
                    end
                end
                S_EXEC_WAIT: begin
                    // halt outranks a simultaneous jump; the PC stays on the halted instruction's successor
                    if (exec_done) begin
                        if (halt) begin
                            halted <= 1'b1;
                        end else if (jump_load) begin
                            pc_out <= jump_addr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: random programs and exec handshakes against an
// instruction-level reference model (PC, operand bytes, per-instruction latency).
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  mem_data_in;
    logic [1:0]  instr_len;
    logic        exec_done = 1'b0;
    logic        jump_load = 1'b0;
    logic [15:0] jump_addr = 16'h0000;
    logic        halt = 1'b0;
    logic [15:0] mem_address;
    logic        mem_read;
    logic [15:0] pc_out;
    logic [7:0]  opcode_out;
    logic [7:0]  operand_1;
    logic [7:0]  operand_2;
    logic        load_origin;
    logic        fetch_done;
    logic        halted;
    logic        fault;

    logic [7:0]  mem [0:65535];
    int          n_cmp = 0;
    int          n_bad = 0;

    // reference model: architectural state after each completed instruction fetch
    logic [15:0] m_pc;
    logic [7:0]  m_op, m_op1, m_op2;
    bit          m_halted;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .mem_data_in (mem_data_in),
        .instr_len   (instr_len),
        .exec_done   (exec_done),
        .jump_load   (jump_load),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .pc_out      (pc_out),
        .opcode_out  (opcode_out),
        .operand_1   (operand_1),
        .operand_2   (operand_2),
        .load_origin (load_origin),
        .fetch_done  (fetch_done),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // memory and a toy decoder: the low two opcode bits give the byte count
    assign mem_data_in = mem[mem_address];
    assign instr_len   = opcode_out[1:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic quiet();
        exec_done = 1'b0;
        jump_load = 1'b0;
        halt      = 1'b0;
    endtask

    task automatic drive_noise();
        exec_done = 1'($urandom_range(0, 1));
        jump_load = 1'($urandom_range(0, 1));
        halt      = 1'($urandom_range(0, 1));
        jump_addr = 16'($urandom);
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        @(negedge clk);
        check("rst_pc", pc_out, 32'h0);
        check("rst_addr", mem_address, 32'h0);
        check("rst_ir", {opcode_out, operand_1, operand_2}, 32'h0);
        check("rst_flags", {mem_read, fetch_done, halted, fault}, 32'h0);
        reset = 1'b0;
        #1;
        check("init_load_origin", load_origin, 32'h1);
        m_pc     = 16'hF000;
        m_op     = 8'h00;
        m_op1    = 8'h00;
        m_op2    = 8'h00;
        m_halted = 1'b0;
    endtask

    // Starts at the negedge of the INIT or exec_done cycle; the instruction completes 4*len cycles later.
    task automatic fetch_insn();
        logic [1:0]  raw;
        logic [15:0] a;
        int          len, cnt, reads;
        bit          trap, done;
        raw = mem[m_pc][1:0];
        len = (raw == 2'd0) ? 1 : int'(raw);
`ifdef FETCH_LEN_TRAP_EN
        trap = (raw == 2'd0);
`else
        trap = 1'b0;
`endif
        cnt = 0;
        reads = 0;
        done = 1'b0;
        while (!done && cnt < 16) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) check("start_pc", pc_out, m_pc);
            if (mem_read) begin
                a = m_pc + 16'(reads);
                check("read_addr", mem_address, a);
                reads++;
            end
            if (fetch_done || halted) done = 1'b1;
            else drive_noise();
        end
        quiet();
        if (trap) begin
            check("trap_cycles", cnt, 5);
            check("trap_no_done", fetch_done, 32'h0);
            check("trap_flags", {halted, fault}, 32'h3);
            m_op = mem[m_pc];
            m_pc = m_pc + 16'd1;
            check("trap_pc", pc_out, m_pc);
            m_halted = 1'b1;
            return;
        end
        check("done_cycles", cnt, 4 * len);
        check("read_count", reads, len);
        m_op = mem[m_pc];
        a = m_pc + 16'd1;
        if (len >= 2) m_op1 = mem[a];
        a = m_pc + 16'd2;
        if (len == 3) m_op2 = mem[a];
        m_pc = m_pc + 16'(len);
        check("opcode", opcode_out, m_op);
        check("operand_1", operand_1, m_op1);
        check("operand_2", operand_2, m_op2);
        check("pc_after", pc_out, m_pc);
        check("no_fault", {halted, fault}, 32'h0);
    endtask

    // Called right after fetch_done was seen; ends at the negedge that drives exec_done.
    task automatic exec_phase(input bit j, input bit h, input logic [15:0] addr);
        int idle;
        int bad;
        idle = $urandom_range(0, 3);
        @(negedge clk);
        check("done_pulse", fetch_done, 32'h0);
        repeat (idle) begin
            exec_done = 1'b0;
            jump_load = 1'($urandom_range(0, 1));
            halt      = 1'($urandom_range(0, 1));
            jump_addr = 16'($urandom);
            @(negedge clk);
            check("wait_hold", {mem_read, fetch_done, pc_out}, {16'h0, 2'b00, m_pc});
        end
        exec_done = 1'b1;
        jump_load = j;
        halt      = h;
        jump_addr = addr;
        if (h) begin
            @(negedge clk);
            quiet();
            check("halted", halted, 32'h1);
            check("halt_pc", pc_out, m_pc);
            bad = 0;
            repeat (20) begin
                drive_noise();
                @(negedge clk);
                if (mem_read || fetch_done || !halted || pc_out != m_pc) bad++;
            end
            quiet();
            check("halt_frozen", bad, 0);
            m_halted = 1'b1;
        end else if (j) begin
            m_pc = addr;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        int reads;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'hF000] = 8'h3E;      // 2-byte LDI_A
        mem[16'hF001] = 8'hF5;
        mem[16'hF002] = 8'h01;      // 1-byte
        mem[16'hFFFE] = 8'hC3;      // 3-byte spanning the wrap
        mem[16'h1234] = 8'h40;      // length 0

        do_reset();
        fetch_insn();
        check("ldi_operand", operand_1, 32'hF5);
        exec_phase(1'b1, 1'b0, 16'hFFFE);
        fetch_insn();
        check("wrap_pc", pc_out, 32'h0001);
        exec_phase(1'b1, 1'b0, 16'h1234);
        fetch_insn();

        do_reset();
        fetch_insn();
        exec_phase(1'b0, 1'b0, 16'h0000);
        fetch_insn();
        check("pre_halt_pc", pc_out, 32'hF003);
        exec_phase(1'b1, 1'b1, 16'h4321);

        // reset during READ_BYTE of the second byte clears asynchronously
        do_reset();
        cnt = 0;
        reads = 0;
        while (reads < 2 && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (mem_read) reads++;
        end
        check("mid_reads", reads, 2);
        reset = 1'b1;
        #1;
        check("async_pc", pc_out, 32'h0);
        check("async_addr", mem_address, 32'h0);
        check("async_ir", {opcode_out, operand_1, operand_2}, 32'h0);
        check("async_flags", {mem_read, fetch_done, halted, fault}, 32'h0);
        do_reset();
        fetch_insn();

        for (int k = 0; k < 40; k++) begin
            if (!m_halted) begin
                exec_phase($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                           ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(16'hFFFD, 16'hFFFF)));
            end
            if (m_halted) do_reset();
            fetch_insn();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
